// File: rtl/cs_pkg.sv
// Shared definitions for the current-sensor ADC sequencer: word geometry,
// command field positions and the sequencer state encoding.
`timescale 1ns/1ps
package cs_pkg;

  localparam int CMD_LEN      = 16;
  localparam int NUM_CHANNELS = 8;
  localparam int CH_W         = 3;

  localparam int CMD_UPDATE_BIT = 15;
  localparam int CMD_REPEAT_BIT = 14;
  localparam int CMD_MASK_MSB   = 13;
  localparam int CMD_MASK_LSB   = 6;

  localparam logic [CMD_LEN-1:0] NOP_WORD = '0;

  // Each frame-issuing phase has an ISSUE half (waiting to launch) and a
  // WAIT half (waiting for the SPI engine to report done).
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_ISSUE,
    ST_CMD_WAIT,
    ST_DISC_ISSUE,
    ST_DISC_WAIT,
    ST_READ_ISSUE,
    ST_READ_WAIT
  } state_e;

  function automatic logic [CMD_LEN-1:0] build_cmd(input logic rep,
                                                   input logic [NUM_CHANNELS-1:0] mask);
    logic [CMD_LEN-1:0] w;
    w = NOP_WORD;
    w[CMD_UPDATE_BIT] = 1'b1;
    w[CMD_REPEAT_BIT] = rep;
    w[CMD_MASK_MSB:CMD_MASK_LSB] = mask;
    return w;
  endfunction

endpackage

// File: rtl/cs_chan_select.sv
// Channel walker: next enabled channel strictly above the current one, a wrap
// flag when none remains, and the lowest enabled channel.
`timescale 1ns/1ps
module cs_chan_select
  import cs_pkg::*;
(
  input  logic [NUM_CHANNELS-1:0] mask,
  input  logic [CH_W-1:0]         cur,
  output logic [CH_W-1:0]         next_idx,
  output logic                    wrap,
  output logic [CH_W-1:0]         lowest_idx
);

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    next_idx   = cur;
    wrap       = 1'b1;
    lowest_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_idx = CH_W'(i);
        if (i > int'(cur)) begin
          next_idx = CH_W'(i);
          wrap     = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cs_adc_sequencer.sv
// Initiator for the current-sensor ADC: sends the update command, drops the
// settling frames, then reads and tags one word per enabled channel.
`timescale 1ns/1ps
module cs_adc_sequencer
  import cs_pkg::*;
#(
  parameter int DISCARD_FRAMES = 2,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  input  logic                    repeat_en,
  output logic                    busy,
  output logic [CMD_LEN-1:0]      sample_data,
  output logic [CH_W-1:0]         sample_chan,
  output logic                    sample_valid,
  output logic                    scan_done,
  output logic                    spi_start,
  output logic [CMD_LEN-1:0]      spi_tx_data,
  input  logic                    spi_busy,
  input  logic                    spi_done,
  input  logic [CMD_LEN-1:0]      spi_rx_data
);

  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int DISC_W = (DISCARD_FRAMES > 1) ? $clog2(DISCARD_FRAMES) : 1;

  state_e                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    rep_q, rep_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [DISC_W-1:0]       disc_cnt_q, disc_cnt_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
  logic                    stop_pend_q, stop_pend_d;
  logic                    busy_q, busy_d;
  logic                    spi_start_q, spi_start_d;
  logic [CMD_LEN-1:0]      spi_tx_q, spi_tx_d;
  logic [CMD_LEN-1:0]      sample_data_q, sample_data_d;
  logic [CH_W-1:0]         sample_chan_q, sample_chan_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    scan_done_q, scan_done_d;

  logic [CH_W-1:0] next_idx, lowest_idx;
  logic            wrap;
  logic            issue_ok;

  cs_chan_select u_chan_select (
    .mask       (mask_q),
    .cur        (ch_q),
    .next_idx   (next_idx),
    .wrap       (wrap),
    .lowest_idx (lowest_idx)
  );

  assign issue_ok = !spi_busy && (gap_cnt_q == '0);

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    rep_d          = rep_q;
    ch_d           = ch_q;
    disc_cnt_d     = disc_cnt_q;
    gap_cnt_d      = (gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : gap_cnt_q;
    stop_pend_d    = stop_pend_q | (stop && state_q != ST_IDLE);
    busy_d         = (state_q != ST_IDLE);
    spi_start_d    = 1'b0;
    spi_tx_d       = spi_tx_q;
    sample_data_d  = sample_data_q;
    sample_chan_d  = sample_chan_q;
    sample_valid_d = 1'b0;
    scan_done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && (chan_mask != '0)) begin
          mask_d     = chan_mask;
          rep_d      = repeat_en;
          gap_cnt_d  = '0;
          disc_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_CMD_ISSUE;
        end
      end
      ST_CMD_ISSUE, ST_DISC_ISSUE, ST_READ_ISSUE: begin
        // The gap between frames is itself a frame boundary for stop.
        if (stop_pend_q) begin
          state_d = ST_IDLE;
        end else if (issue_ok) begin
          spi_start_d = 1'b1;
          spi_tx_d    = (state_q == ST_CMD_ISSUE) ? build_cmd(rep_q, mask_q) : NOP_WORD;
          state_d     = (state_q == ST_CMD_ISSUE)  ? ST_CMD_WAIT  :
                        (state_q == ST_DISC_ISSUE) ? ST_DISC_WAIT : ST_READ_WAIT;
        end
      end
      ST_CMD_WAIT: begin
        if (spi_done) begin
          gap_cnt_d  = GAP_W'(GAP_CYCLES);
          disc_cnt_d = '0;
          state_d    = stop_pend_d ? ST_IDLE : ST_DISC_ISSUE;
        end
      end
      ST_DISC_WAIT: begin
        if (spi_done) begin
          gap_cnt_d = GAP_W'(GAP_CYCLES);
          if (stop_pend_d) begin
            state_d = ST_IDLE;
          end else if (disc_cnt_q == DISC_W'(DISCARD_FRAMES - 1)) begin
            ch_d    = lowest_idx;
            state_d = ST_READ_ISSUE;
          end else begin
            disc_cnt_d = disc_cnt_q + 1'b1;
            state_d    = ST_DISC_ISSUE;
          end
        end
      end
      ST_READ_WAIT: begin
        if (spi_done) begin
          gap_cnt_d      = GAP_W'(GAP_CYCLES);
          sample_valid_d = 1'b1;
          sample_data_d  = spi_rx_data;
          sample_chan_d  = ch_q;
          scan_done_d    = wrap;
          if (stop_pend_d || (wrap && !rep_q)) begin
            state_d = ST_IDLE;
          end else begin
            ch_d    = wrap ? lowest_idx : next_idx;
            state_d = ST_READ_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mask_q         <= '0;
      rep_q          <= 1'b0;
      ch_q           <= '0;
      disc_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      stop_pend_q    <= 1'b0;
      busy_q         <= 1'b0;
      spi_start_q    <= 1'b0;
      spi_tx_q       <= '0;
      sample_data_q  <= '0;
      sample_chan_q  <= '0;
      sample_valid_q <= 1'b0;
      scan_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      rep_q          <= rep_d;
      ch_q           <= ch_d;
      disc_cnt_q     <= disc_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      stop_pend_q    <= stop_pend_d;
      busy_q         <= busy_d;
      spi_start_q    <= spi_start_d;
      spi_tx_q       <= spi_tx_d;
      sample_data_q  <= sample_data_d;
      sample_chan_q  <= sample_chan_d;
      sample_valid_q <= sample_valid_d;
      scan_done_q    <= scan_done_d;
    end
  end

  assign busy         = busy_q;
  assign spi_start    = spi_start_q;
  assign spi_tx_data  = spi_tx_q;
  assign sample_data  = sample_data_q;
  assign sample_chan  = sample_chan_q;
  assign sample_valid = sample_valid_q;
  assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_cs_adc_sequencer.sv
// Directed bench for cs_adc_sequencer: SPI slave model, sample scoreboard and
// frame log, checked with immediate assertions.
`timescale 1ns/1ps
module tb_cs_adc_sequencer;
  import cs_pkg::*;

  localparam int GAP = 4;
  localparam int LAT = 4;

  logic        sysclk = 1'b0;
  logic        rst_n, start, stop, repeat_en;
  logic [7:0]  chan_mask;
  logic        busy, sample_valid, scan_done, spi_start;
  logic [15:0] sample_data, spi_tx_data, spi_rx_data;
  logic [2:0]  sample_chan;
  logic        spi_busy, spi_done;

  always #5 sysclk = ~sysclk;

  cs_adc_sequencer #(.DISCARD_FRAMES(2), .GAP_CYCLES(GAP)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .stop(stop),
    .chan_mask(chan_mask), .repeat_en(repeat_en), .busy(busy),
    .sample_data(sample_data), .sample_chan(sample_chan),
    .sample_valid(sample_valid), .scan_done(scan_done),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data)
  );

  typedef struct packed {
    logic [2:0]  chan;
    logic [15:0] data;
    logic        scan;
  } samp_t;

  samp_t       exp_q[$];
  logic [15:0] tx_log[$];
  int checks = 0, errors = 0;
  int cyc = 0, ncyc = 0, frames = 0, cur_frame = 0;
  int samples_seen = 0, scans_seen = 0, gap_viol = 0;
  int last_done_cyc = -100, last_sample_cyc = 0, busy_fall_cyc = -1;
  logic busy_prev = 1'b0, busy_ever = 1'b0;

  function automatic logic [15:0] rx_word(input int n);
    return 16'(((n & 255) << 8) | ((n + 1) & 255));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge sysclk) cyc <= cyc + 1;

  // SPI slave: busy for LAT cycles after a start, then a one-cycle done.
  initial begin
    int cnt;
    cnt = 0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx_data = '0;
    forever begin
      @(posedge sysclk); #1;
      spi_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_busy = 1'b0; spi_done = 1'b1;
          spi_rx_data = rx_word(cur_frame);
          last_done_cyc = cyc;
        end
      end else if (spi_start) begin
        if (cyc - last_done_cyc - 1 < GAP) gap_viol++;
        tx_log.push_back(spi_tx_data);
        cur_frame = frames; frames++;
        spi_busy = 1'b1; cnt = LAT;
        $display("frame %0d tx=%04h", cur_frame, spi_tx_data);
      end
    end
  end

  // Output monitor: scoreboard pops on every sample strobe.
  initial begin
    samp_t e;
    forever begin
      @(negedge sysclk);
      ncyc++;
      if (busy) busy_ever = 1'b1;
      if (busy_prev && !busy) busy_fall_cyc = ncyc;
      busy_prev = busy;
      if (scan_done) scans_seen++;
      if (sample_valid) begin
        samples_seen++;
        last_sample_cyc = ncyc;
        $display("sample chan=%0d data=%04h scan_done=%0b", sample_chan, sample_data, scan_done);
        chk("sample_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sample_chan", 32'(sample_chan), 32'(e.chan));
          chk("sample_data", 32'(sample_data), 32'(e.data));
          chk("sample_scan_done", 32'(scan_done), 32'(e.scan));
        end
      end
    end
  end

  task automatic pulse_start(input logic [7:0] m, input logic r);
    @(negedge sysclk);
    chan_mask = m; repeat_en = r; start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge sysclk); n++; end
    chk({tag, "_idle_timeout"}, 32'(n < 3000), 32'd1);
    repeat (3) @(negedge sysclk);
  endtask

  task automatic wait_samples(input int target, input string tag);
    int n;
    n = 0;
    while (samples_seen < target && n < 3000) begin @(negedge sysclk); n++; end
    chk({tag, "_sample_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base, s0, sc0;
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; chan_mask = '0; repeat_en = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_spi_start", 32'(spi_start), 0);
    chk("rst_tx", 32'(spi_tx_data), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_scan", 32'(scan_done), 0);
    chk("rst_data", 32'(sample_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);

    // Full mask, single scan
    tx_log.delete(); last_done_cyc = -100; base = frames; sc0 = scans_seen;
    for (int i = 0; i < 8; i++) exp_q.push_back('{chan: 3'(i), data: rx_word(base + 3 + i), scan: (i == 7)});
    pulse_start(8'hFF, 1'b0);
    chk("t1_busy_start", 32'(busy), 1);
    wait_idle("t1");
    chk("t1_frames", 32'(tx_log.size()), 11);
    chk("t1_cmd", 32'(tx_log[0]), 32'h0000_BFC0);
    chk("t1_disc", 32'(tx_log[2]), 0);
    chk("t1_read", 32'(tx_log[10]), 0);
    chk("t1_left", 32'(exp_q.size()), 0);
    chk("t1_scans", 32'(scans_seen - sc0), 1);
    chk("t1_busy_fall", 32'(busy_fall_cyc), 32'(last_sample_cyc + 1));

    // Sparse mask and gap spacing
    tx_log.delete(); last_done_cyc = -100; base = frames; gap_viol = 0;
    exp_q.push_back('{chan: 3'd2, data: rx_word(base + 3), scan: 1'b0});
    exp_q.push_back('{chan: 3'd5, data: rx_word(base + 4), scan: 1'b1});
    pulse_start(8'b0010_0100, 1'b0);
    wait_idle("t2");
    chk("t2_frames", 32'(tx_log.size()), 5);
    chk("t2_cmd", 32'(tx_log[0]), 32'h0000_8900);
    chk("t2_left", 32'(exp_q.size()), 0);
    chk("t2_gap_viol", 32'(gap_viol), 0);

    // Repeat scans, then stop during a chan-0 frame
    tx_log.delete(); last_done_cyc = -100; base = frames; s0 = samples_seen; sc0 = scans_seen;
    for (int k = 0; k < 7; k++)
      exp_q.push_back('{chan: (k % 2 == 0) ? 3'd0 : 3'd7, data: rx_word(base + 3 + k), scan: (k % 2 == 1)});
    pulse_start(8'h81, 1'b1);
    wait_samples(s0 + 6, "t3");
    n = 0;
    while (!spi_busy && n < 100) begin @(negedge sysclk); n++; end
    chk("t3_frame_wait", 32'(n < 100), 1);
    stop = 1'b1;
    @(negedge sysclk);
    stop = 1'b0;
    wait_idle("t3");
    chk("t3_frames", 32'(tx_log.size()), 10);
    chk("t3_cmd", 32'(tx_log[0]), 32'h0000_E040);
    chk("t3_disc", 32'(tx_log[1] | tx_log[2]), 0);
    chk("t3_left", 32'(exp_q.size()), 0);
    chk("t3_scans", 32'(scans_seen - sc0), 3);
    chk("t3_busy_fall", 32'(busy_fall_cyc), 32'(last_sample_cyc + 1));

    // Zero mask is ignored
    tx_log.delete(); busy_ever = 1'b0;
    pulse_start(8'h00, 1'b0);
    repeat (20) @(negedge sysclk);
    chk("t4_no_busy", 32'(busy_ever), 0);
    chk("t4_no_frames", 32'(tx_log.size()), 0);

    // Start while busy is ignored
    tx_log.delete(); last_done_cyc = -100; base = frames;
    exp_q.push_back('{chan: 3'd2, data: rx_word(base + 3), scan: 1'b0});
    exp_q.push_back('{chan: 3'd5, data: rx_word(base + 4), scan: 1'b1});
    pulse_start(8'b0010_0100, 1'b0);
    repeat (8) @(negedge sysclk);
    pulse_start(8'hFF, 1'b1);
    wait_idle("t4b");
    chk("t4b_frames", 32'(tx_log.size()), 5);
    chk("t4b_cmd", 32'(tx_log[0]), 32'h0000_8900);
    chk("t4b_left", 32'(exp_q.size()), 0);

    // Reset during the second discard frame
    tx_log.delete(); last_done_cyc = -100;
    pulse_start(8'hFF, 1'b0);
    n = 0;
    while (tx_log.size() < 3 && n < 200) begin @(negedge sysclk); n++; end
    chk("t5_disc_wait", 32'(n < 200), 1);
    rst_n = 1'b0;
    @(negedge sysclk);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_spi_start", 32'(spi_start), 0);
    chk("t5_tx", 32'(spi_tx_data), 0);
    chk("t5_data", 32'(sample_data), 0);
    chk("t5_chan", 32'(sample_chan), 0);
    rst_n = 1'b1;
    s0 = samples_seen;
    repeat (20) @(negedge sysclk);
    chk("t5_no_sample", 32'(samples_seen - s0), 0);
    chk("t5_idle", 32'(busy), 0);
    tx_log.delete(); last_done_cyc = -100; base = frames;
    exp_q.push_back('{chan: 3'd2, data: rx_word(base + 3), scan: 1'b0});
    exp_q.push_back('{chan: 3'd5, data: rx_word(base + 4), scan: 1'b1});
    pulse_start(8'b0010_0100, 1'b0);
    wait_idle("t5b");
    chk("t5b_frames", 32'(tx_log.size()), 5);
    chk("t5b_cmd", 32'(tx_log[0]), 32'h0000_8900);
    chk("t5b_left", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_adc_sequencer.md
Name: cs_adc_sequencer

Overview:
- FPGA-side controller for the current-sensor ADC. It is the initiator end of the 16-bit command/response word protocol that the ADC answers.
- Builds and sends the update command, discards the ADC's invalid settling frames, then reads one word per enabled channel in ascending channel order.
- Tags each reading with its channel number and presents it to the motor-control logic.
- Sits between the host control registers and a 16-bit SPI master word engine.

Parameters:
- NUM_CHANNELS, 8, number of sensor channels; mask width.
- CMD_LEN, 16, SPI word width.
- DISCARD_FRAMES, 2, invalid frames the ADC returns after each command.
- GAP_CYCLES, 4, minimum idle sysclk cycles between frames; lets the ADC see done deassert.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a sequence.
- stop  in  1  one-cycle request to end a repeat sequence.
- chan_mask  in  NUM_CHANNELS  channel enables; bit i enables channel i.
- repeat_en  in  1  continuous scanning when set.
- busy  out  1  high from accepted start until return to IDLE.
- sample_data  out  CMD_LEN  captured channel reading.
- sample_chan  out  3  channel index of sample_data.
- sample_valid  out  1  one-cycle strobe qualifying sample_data and sample_chan.
- scan_done  out  1  one-cycle strobe after the last enabled channel of each scan.
- spi_start  out  1  one-cycle word-transfer request to the SPI master.
- spi_tx_data  out  CMD_LEN  word to shift out; held stable from spi_start until spi_done.
- spi_busy  in  1  SPI master transfer in progress.
- spi_done  in  1  one-cycle strobe marking the end of a transfer.
- spi_rx_data  in  CMD_LEN  received word; valid in the spi_done cycle.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched mask, repeat flag, counters and stop_pend cleared. Reset mid-transfer abandons the frame; a later spi_done is ignored while in IDLE.
- Command word: {1'b1, repeat_en, chan_mask[7:0], 6'b0}. Read and discard frames transmit 16'h0000.
- IDLE:
  - Accept start only if chan_mask != 0. start with a zero mask is ignored and busy stays 0.
  - On accept, latch mask and repeat_en, and go to CMD.
  - A stop arriving in the same cycle as start is ignored; the start is accepted.
- Frame handshake, used by CMD, DISC and READ:
  - Wait for spi_busy==0 and gap counter expired, then pulse spi_start for 1 cycle.
  - Wait for spi_done. On spi_done, reload the gap counter with GAP_CYCLES.
  - The first frame after IDLE needs no gap.
- CMD: one frame; the response is discarded. Then go to DISC.
- DISC: DISCARD_FRAMES frames, responses discarded, counted 0..DISCARD_FRAMES-1. Then go to READ with ch = lowest set bit of the latched mask.
- READ:
  - One frame per enabled channel.
  - In the cycle after spi_done: sample_valid=1, sample_data=spi_rx_data (registered), sample_chan=ch.
  - ch then advances to the next set bit above ch.
  - After the highest set bit: scan_done pulses in the same cycle as that sample_valid.
    - If repeat is latched and no stop is pending: ch wraps to the lowest set bit and READ continues, with no new command or discard frames.
    - Otherwise: go to IDLE; busy falls the cycle after scan_done.
- stop:
  - Sets stop_pend while busy. The current frame always completes and its sample is reported.
  - The FSM then goes to IDLE at the next frame boundary and does not finish the scan.
  - scan_done pulses only if that frame was the last channel.
- start while busy is ignored. chan_mask and repeat_en changes while busy have no effect until the next accepted start.
- An spi_done arriving while not waiting for one is ignored.

Decomposition:
- Shared package cs_pkg:
  - CMD_LEN and NUM_CHANNELS.
  - Command bit positions: CMD_UPDATE_BIT=15, CMD_REPEAT_BIT=14, CMD_MASK_MSB=13, CMD_MASK_LSB=6.
  - FSM state encoding: IDLE, CMD, DISC, READ, each with ISSUE/WAIT sub-phase.
  - NOP word 16'h0000.
- One sub-module, cs_chan_select: combinational; given mask and current index, returns the next set index strictly above it, a wrap flag, and the lowest set index.

Test Plan:
- Mask 8'hFF, repeat 0, SPI model returning 16'hi00(i+1)-style words:
  - Exactly 11 frames (1 cmd + 2 discard + 8 reads).
  - Command frame tx = 16'hBFC0.
  - 8 sample_valid strobes with chan 0..7.
  - scan_done on chan 7; busy falls one cycle later.
- Mask 8'b0010_0100, repeat 0:
  - Command frame = 16'h8900.
  - Samples reported on chan 2 then chan 5 only.
  - Gap of at least GAP_CYCLES between every spi_done and the next spi_start.
- Mask 8'h81, repeat 1, run 3 scans, then stop during a chan-0 frame:
  - Command and discard frames only once.
  - Samples alternate chan 0/7.
  - After stop, the chan-0 sample is reported, then busy=0 with no scan_done.
- start with mask 0 -> no spi_start, busy stays 0. start while busy -> no second command frame.
- rst_n low during the second discard frame, with spi_done arriving later -> all outputs 0, no sample_valid. A fresh start re-issues the command frame.
